// File: rtl/vc_iter_divider.sv
// rtl/vc_iter_divider.sv - multi-cycle restoring unsigned divider with domain-tagged results
// One subtract/shift step per cycle; latency is p_nbits cycles regardless of operands.
module vc_iter_divider #(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_val,
  output logic               req_rdy,
  input  logic               req_domain,
  input  logic [p_nbits-1:0] req_dividend,
  input  logic [p_nbits-1:0] req_divisor,
  output logic               resp_val,
  input  logic               resp_rdy,
  output logic               resp_domain,
  output logic [p_nbits-1:0] resp_quot,
  output logic [p_nbits-1:0] resp_rem
);

  localparam int CW = (p_nbits > 1) ? $clog2(p_nbits) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q;
  logic               req_rdy_q;
  logic               resp_val_q;
  logic               dom_q;
  logic [p_nbits-1:0] q_q;
  logic [p_nbits-1:0] d_q;
  logic [p_nbits:0]   r_q;
  logic [CW-1:0]      cnt_q;

  logic [p_nbits:0]   rs_d;
  logic [p_nbits:0]   diff_d;

  // Extra msb of the subtract is the borrow: set means the divisor did not fit.
  always_comb begin
    rs_d   = {r_q[p_nbits-1:0], q_q[p_nbits-1]};
    diff_d = rs_d - {1'b0, d_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      req_rdy_q  <= 1'b1;
      resp_val_q <= 1'b0;
      dom_q      <= 1'b0;
      q_q        <= '0;
      d_q        <= '0;
      r_q        <= '0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_val) begin
            state_q   <= CALC;
            req_rdy_q <= 1'b0;
            dom_q     <= req_domain;
            q_q       <= req_dividend;
            d_q       <= req_divisor;
            r_q       <= '0;
            cnt_q     <= CW'(p_nbits - 1);
          end
        end
        CALC: begin
          if (!diff_d[p_nbits]) begin
            r_q <= diff_d;
            q_q <= {q_q[p_nbits-2:0], 1'b1};
          end else begin
            r_q <= rs_d;
            q_q <= {q_q[p_nbits-2:0], 1'b0};
          end
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q    <= DONE;
            resp_val_q <= 1'b1;
          end
        end
        DONE: begin
          if (resp_rdy) begin
            state_q    <= IDLE;
            resp_val_q <= 1'b0;
            req_rdy_q  <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          req_rdy_q  <= 1'b1;
          resp_val_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_rdy     = req_rdy_q;
  assign resp_val    = resp_val_q;
  assign resp_domain = dom_q;
  assign resp_quot   = q_q;
  assign resp_rem    = r_q[p_nbits-1:0];

endmodule

// File: tb/tb_vc_iter_divider.sv
// tb/tb_vc_iter_divider.sv - self-checking bench for vc_iter_divider
// Directed table, corner-case sequences and random operands against an arithmetic model.
module tb_vc_iter_divider;

  localparam int N = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_val = 1'b0;
  logic          req_rdy;
  logic          req_domain = 1'b0;
  logic [N-1:0]  req_dividend = '0;
  logic [N-1:0]  req_divisor = '0;
  logic          resp_val;
  logic          resp_rdy = 1'b1;
  logic          resp_domain;
  logic [N-1:0]  resp_quot;
  logic [N-1:0]  resp_rem;

  int n_checks = 0;
  int n_fail   = 0;

  vc_iter_divider #(.p_nbits(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_val      (req_val),
    .req_rdy      (req_rdy),
    .req_domain   (req_domain),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .resp_val     (resp_val),
    .resp_rdy     (resp_rdy),
    .resp_domain  (resp_domain),
    .resp_quot    (resp_quot),
    .resp_rem     (resp_rem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        dom;
    logic [31:0] eq;
    logic [31:0] er;
    int          hold;
    bit          interfere;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: plain integer division, with the divide-by-zero convention.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    return {a / b, a % b};
  endfunction

  task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic dom);
    int w;
    @(negedge clk);
    req_val = 1'b1; req_dividend = a; req_divisor = b; req_domain = dom;
    w = 0;
    while (!req_rdy && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("accept_wait_bound", 32'(w < 100), 32'd1);
    @(posedge clk);
    #1;
    req_val = 1'b0;
    check("req_rdy_after_accept", 32'(req_rdy), 32'd0);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic dom,
                        input logic [31:0] eq, input logic [31:0] er,
                        input int hold, input bit interfere);
    int lat;
    resp_rdy = (hold == 0);
    accept(a, b, dom);
    lat = 0;
    while (!resp_val && lat < 100) begin
      if (interfere) begin
        req_val      = 1'($urandom);
        req_domain   = ~req_domain;
        req_dividend = $urandom;
        req_divisor  = $urandom;
      end
      @(posedge clk);
      #1;
      lat++;
      if (interfere) check("req_rdy_low_in_calc", 32'(req_rdy), 32'd0);
    end
    req_val = 1'b0;
    check("latency", 32'(lat), 32'(N));
    check("resp_quot", resp_quot, eq);
    check("resp_rem", resp_rem, er);
    check("resp_domain", 32'(resp_domain), 32'(dom));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check("bp_resp_val", 32'(resp_val), 32'd1);
      check("bp_quot", resp_quot, eq);
      check("bp_rem", resp_rem, er);
      check("bp_domain", 32'(resp_domain), 32'(dom));
      check("bp_req_rdy", 32'(req_rdy), 32'd0);
    end
    resp_rdy = 1'b1;
    @(posedge clk);
    #1;
    check("post_hs_resp_val", 32'(resp_val), 32'd0);
    check("post_hs_req_rdy", 32'(req_rdy), 32'd1);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{32'd100,        32'd7, 1'b0, 32'd14,         32'd2,         0, 1'b0};
    vecs[1] = '{32'h0000_1234,  32'd0, 1'b1, 32'hFFFF_FFFF,  32'h0000_1234, 0, 1'b0};
    vecs[2] = '{32'hFFFF_FFFF,  32'd1, 1'b0, 32'hFFFF_FFFF,  32'd0,         0, 1'b0};
    vecs[3] = '{32'd5,          32'd9, 1'b1, 32'd0,          32'd5,         0, 1'b0};
    vecs[4] = '{32'd0,          32'd3, 1'b0, 32'd0,          32'd0,         0, 1'b0};
    vecs[5] = '{32'd1000,       32'd33, 1'b0, 32'd30,        32'd10,        5, 1'b0};
    vecs[6] = '{32'd123456789,  32'd1000, 1'b1, 32'd123456,  32'd789,       0, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_rdy", 32'(req_rdy), 32'd1);
    check("rst_resp_val", 32'(resp_val), 32'd0);
    check("rst_quot", resp_quot, 32'd0);
    check("rst_rem", resp_rem, 32'd0);
    check("rst_domain", 32'(resp_domain), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].dom, vecs[i].eq, vecs[i].er,
             vecs[i].hold, vecs[i].interfere);

    // Reset in the middle of CALC discards the operation
    accept(32'd77, 32'd5, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_resp_val", 32'(resp_val), 32'd0);
    check("midrst_req_rdy", 32'(req_rdy), 32'd1);
    check("midrst_quot", resp_quot, 32'd0);
    check("midrst_domain", 32'(resp_domain), 32'd0);
    repeat (N + 2) @(posedge clk);
    #1;
    check("midrst_no_resp", 32'(resp_val), 32'd0);
    run_op(32'd9, 32'd2, 1'b0, 32'd4, 32'd1, 0, 1'b0);

    // Reset coincident with req_val: not accepted
    @(negedge clk);
    reset = 1'b1; req_val = 1'b1; req_dividend = 32'd50; req_divisor = 32'd3; req_domain = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0; req_val = 1'b0;
    check("rst_req_not_accepted", 32'(req_rdy), 32'd1);
    repeat (N + 2) @(posedge clk);
    #1;
    check("rst_req_no_resp", 32'(resp_val), 32'd0);
    check("rst_req_domain", 32'(resp_domain), 32'd0);

    // Random operands against the arithmetic model
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, b;
      logic [63:0] e;
      a = $urandom;
      case (i % 4)
        0: b = $urandom;
        1: b = 32'($urandom_range(1, 255));
        2: b = (i % 8 == 2) ? 32'd0 : 32'($urandom_range(0, 15));
        default: b = a >> $urandom_range(0, 31);
      endcase
      e = ref_div(a, b);
      run_op(a, b, 1'($urandom), e[63:32], e[31:0], (i % 5 == 0) ? 2 : 0, i[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
